// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multiport register file.
// Provides default widths and the write-address one-hot decoder.
package rf_pkg;

    localparam int RF_DATA_W     = 32;
    localparam int RF_ADDR_W     = 4;
    localparam int RF_NUM_RD     = 2;

    // Decoder is sized for the largest supported file; callers truncate.
    localparam int RF_MAX_ADDR_W = 8;
    localparam int RF_MAX_REGS   = 2 ** RF_MAX_ADDR_W;

    function automatic logic [RF_MAX_REGS-1:0] rf_onehot(
        input logic [RF_MAX_ADDR_W-1:0] addr
    );
        logic [RF_MAX_REGS-1:0] sel;
        sel       = '0;
        sel[addr] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: 1-cycle latency, valid strobe, zero-entry mask.
// Ports: clk, rst, rd_en/rd_addr request, entry (array word at rd_addr),
//   wr_en/wr_addr/wr_data (write-back snoop), rd_data/rd_valid (registered).
// Macro RF_BYPASS_EN: forward same-edge write data (write-first).
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] entry,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic              hit;
    logic [DATA_W-1:0] next_data;

`ifdef RF_BYPASS_EN
    assign hit = wr_en && (rd_addr == wr_addr);
`else
    // Read-first: the snoop inputs play no part in this build.
    logic bypass_unused;
    assign bypass_unused = ^{wr_en, wr_addr, wr_data};
    assign hit           = 1'b0;
`endif

    always_comb begin
        next_data = hit ? wr_data : entry;
        // Zero entry wins even over a forwarded write.
        if (ZERO_REG != 0 && rd_addr == '0)
            next_data = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= next_data;
        end
    end

endmodule

// File: rtl/reg_file_multiport.sv
// Register file: 2**ADDR_W x DATA_W, one synchronous write port and
// NUM_RD registered read ports (ADDR_W up to 8, NUM_RD 1..4).
// Ports: clk, rst (async, active high), wr_en/wr_addr/wr_data,
//   rd_en[NUM_RD], rd_addr (packed per port), rd_data (packed), rd_valid.
// Macro RF_BYPASS_EN: same-edge write is visible to reads (write-first).
module reg_file_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    always_comb begin
        wr_sel = '0;
        if (wr_en)
            wr_sel = NUM_REGS'(rf_onehot(RF_MAX_ADDR_W'(wr_addr)));
        // Entry 0 is hardwired: it stays at its reset value of 0.
        if (ZERO_REG != 0)
            wr_sel[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                mem[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (wr_sel[r])
                    mem[r] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[i]),
            .rd_addr  (addr),
            .entry    (mem[addr]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[i*DATA_W +: DATA_W]),
            .rd_valid (rd_valid[i])
        );
    end

endmodule

// File: doc/reg_file_multiport.md
Name: reg_file_multiport

Overview:
Parametrised register file: NUM_REGS entries of DATA_W bits, one synchronous write port and NUM_RD independent registered read ports. Successor to the single 32-bit register / 4-to-16 decoder / 16-to-1 mux set, integrated as one block. Sits between the datapath ALU (write-back) and operand fetch (read ports). Adds reset, read valid strobes, a hardwired-zero option and optional write-to-read bypass.

Parameters:
DATA_W, 32, width of each entry and of every data port
ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W (derived localparam, not overridable)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
wr_en  input  1  write strobe, sampled on rising clk edge
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  NUM_RD  per-port read request, bit i for port i
rd_addr  input  NUM_RD*ADDR_W  port i address in bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  port i data in bits [i*DATA_W +: DATA_W], registered
rd_valid  output  NUM_RD  bit i high for exactly one cycle after an accepted port-i read

Behaviour:
- Reset: asserting rst immediately clears all entries, rd_data and rd_valid to 0, independent of clk. While rst is high, wr_en and rd_en are ignored. First write is accepted on the first rising edge after rst deasserts.
- Write: if wr_en=1 on a rising edge, entry[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read latency is 1 cycle. If rd_en[i]=1 on edge N, then after edge N, rd_data[i] = entry[rd_addr[i]] as stored before edge N's write, and rd_valid[i]=1.
- If rd_en[i]=0 on edge N, rd_valid[i] drops to 0 and rd_data[i] holds its previous value. No return to z.
- Ports are fully independent. Any number of ports may read the same or different addresses in the same cycle.
- Same-cycle write and read to the same address: the result depends on RF_BYPASS_EN (see Optional Feature).
- ZERO_REG=1: a read of address 0 always returns 0.
- Back-to-back reads every cycle are supported: throughput is 1 read per port per cycle, and rd_valid stays high continuously.
- Write address decode: one-hot decoder qualified by wr_en. No write occurs when wr_en=0, whatever the address.
- Reset mid-stream: any in-flight read is lost (rd_valid forced 0). Register contents are lost.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: when wr_en=1 and rd_en[i]=1 with rd_addr[i]==wr_addr on the same edge, rd_data[i] returns wr_data (write-first). The exception is wr_addr=0 with ZERO_REG=1, which still returns 0.
- Undefined: the same case returns the old entry value (read-first). The new value is visible to reads issued from the next edge onward.

Decomposition:
- Shared package rf_pkg: default DATA_W/ADDR_W/NUM_RD constants, and a function for the one-hot decode of ADDR_W to NUM_REGS.
- One sub-module, rf_read_port: single read port holding the registered rd_data/rd_valid, bypass compare and zero-register masking. Instantiated NUM_RD times via generate.
- The storage array and write decode stay in the top module.

Test Plan:
1. Reset: write 0xDEADBEEF to addr 5, assert rst between edges -> rd_data/rd_valid go 0 without a clock edge; read addr 5 after release -> 0x00000000, rd_valid=1 one cycle later.
2. Basic write/read: write addr i with 0xA5A50000+i for i=0..15, then read port0 addr 3 and port1 addr 12 together -> 0xA5A50003 and 0xA5A5000C, both rd_valid=1 next cycle.
3. Zero register: ZERO_REG=1, write 0xFFFFFFFF to addr 0, then read addr 0 -> 0. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
4. Collision: addr 7 holds 0x11111111; same edge write 0x22222222 to addr 7 and read addr 7 -> 0x22222222 with RF_BYPASS_EN, 0x11111111 without; next-cycle read -> 0x22222222 in both builds.
5. Streaming: rd_en held high for 16 cycles on both ports, sweeping addresses 0..15 and 15..0 -> rd_valid continuously high, data matches scoreboard each cycle. Drop rd_en -> rd_valid=0 and rd_data held.
6. Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=4 -> all four ports read distinct addresses correctly. A write with wr_en=0 to any address leaves contents unchanged.
